// File: rtl/if_unit_pkg.sv
// -----------------------------------------------------------------------------
// if_unit_pkg -- shared control encodings (ctrl_encode_def) for the fetch unit.
//
// Holds the next-PC operation codes produced by the control unit, the fetch
// FSM state encoding and the reset vector. Imported by if_unit and npc_calc;
// nothing here is redefined locally in those files.
// -----------------------------------------------------------------------------
package if_unit_pkg;

    // Fetch FSM states
    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DECODE = 2'd1,
        ST_HALT   = 2'd2
    } if_state_e;

    // Address the PC takes on reset
    localparam logic [31:0] RESET_VECTOR = 32'h0000_3000;

    // Next-PC operation codes (npc_op). Codes 4'hA..4'hF are unassigned and
    // behave as NPC_PLUS4.
    localparam logic [3:0] NPC_NOP   = 4'h0;
    localparam logic [3:0] NPC_PLUS4 = 4'h1;
    localparam logic [3:0] NPC_JUMP  = 4'h2;
    localparam logic [3:0] NPC_JUMPR = 4'h3;
    localparam logic [3:0] NPC_BEQ   = 4'h4;
    localparam logic [3:0] NPC_BNE   = 4'h5;
    localparam logic [3:0] NPC_BGTZ  = 4'h6;
    localparam logic [3:0] NPC_BLEZ  = 4'h7;
    localparam logic [3:0] NPC_BLTZ  = 4'h8;
    localparam logic [3:0] NPC_BGEZ  = 4'h9;

endpackage

// File: rtl/if_unit_npc.sv
// -----------------------------------------------------------------------------
// npc_calc -- combinational next-PC / branch evaluation.
//
// Ports:
//   pc_i       current instruction address
//   instr_i    current instruction word (imm16 = [15:0], index26 = [25:0])
//   npc_op_i   next-PC operation code (NPC_* encodings)
//   rs_data_i  GPR[rs], branch compare operand and jump-register target
//   rt_data_i  GPR[rt], second operand for BEQ/BNE
//   next_pc_o  raw next PC (alignment is handled by the caller)
//
// No delay slot: every target is relative to pc+4 of the current instruction.
// All arithmetic wraps modulo 2^32.
// -----------------------------------------------------------------------------
module npc_calc
    import if_unit_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    input  logic [3:0]  npc_op_i,
    input  logic [31:0] rs_data_i,
    input  logic [31:0] rt_data_i,
    output logic [31:0] next_pc_o
);

    logic        [31:0] pc4;
    logic        [31:0] br_target;
    logic        [31:0] jump_target;
    logic signed [31:0] rs_s;
    logic signed [31:0] rt_s;
    logic               taken;

    // The opcode bits are decoded by the control unit, not here.
    logic unused_instr_hi;
    assign unused_instr_hi = ^instr_i[31:26];

    assign rs_s        = rs_data_i;
    assign rt_s        = rt_data_i;
    assign pc4         = pc_i + 32'd4;
    assign br_target   = pc4 + {{14{instr_i[15]}}, instr_i[15:0], 2'b00};
    assign jump_target = {pc4[31:28], instr_i[25:0], 2'b00};

    always_comb begin
        taken     = 1'b0;
        next_pc_o = pc4;
        case (npc_op_i)
            NPC_JUMP:  next_pc_o = jump_target;
            NPC_JUMPR: next_pc_o = rs_data_i;
            NPC_BEQ:   taken = (rs_s == rt_s);
            NPC_BNE:   taken = (rs_s != rt_s);
            NPC_BGTZ:  taken = (rs_s >  32'sd0);
            NPC_BLEZ:  taken = (rs_s <= 32'sd0);
            NPC_BLTZ:  taken = (rs_s <  32'sd0);
            NPC_BGEZ:  taken = (rs_s >= 32'sd0);
            default:   next_pc_o = pc4;   // PLUS4, NOP and unassigned codes
        endcase
        if (taken) begin
            next_pc_o = br_target;
        end
    end

endmodule

// File: rtl/if_unit.sv
// -----------------------------------------------------------------------------
// if_unit -- instruction fetch unit (FETCH / DECODE / HALT).
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   imem_req      instruction-memory read request (asserted in FETCH)
//   imem_addr     fetch byte address, always equal to pc
//   imem_ack      imem_rdata is valid this cycle
//   imem_rdata    fetched instruction word
//   instr         instruction register feeding decode/control
//   instr_valid   instr is decodable (asserted in DECODE)
//   pc, pc4       address of instr and pc+4 (link address)
//   npc_op        next-PC code from the control unit
//   rs_data       GPR[rs], rt_data GPR[rt]
//   stall         hold the current instruction in DECODE
//   halted        unit is in HALT (absorbing until rst)
//
// Configuration macro IF_ALIGN_CHECK_EN:
//   defined   -> a misaligned next PC (only reachable via JUMPR) loads pc with
//                the offending address and halts.
//   undefined -> the low two bits of the next PC are cleared and fetch goes on.
// -----------------------------------------------------------------------------
module if_unit
    import if_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    input  logic [3:0]  npc_op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        stall,
    output logic        halted
);

    if_state_e   state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] npc_raw;
    logic [31:0] npc_d;
    logic        misalign;

    npc_calc u_npc_calc (
        .pc_i      (pc_q),
        .instr_i   (instr_q),
        .npc_op_i  (npc_op),
        .rs_data_i (rs_data),
        .rt_data_i (rt_data),
        .next_pc_o (npc_raw)
    );

`ifdef IF_ALIGN_CHECK_EN
    assign npc_d    = npc_raw;
    assign misalign = |npc_raw[1:0];
`else
    assign npc_d    = {npc_raw[31:2], 2'b00};
    assign misalign = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            // Abandons any outstanding fetch; an ack in this cycle is dropped.
            state_q <= ST_FETCH;
            pc_q    <= RESET_VECTOR;
            instr_q <= 32'h0000_0000;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (imem_ack) begin
                        instr_q <= imem_rdata;
                        state_q <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (!stall) begin
                        if (npc_op == NPC_NOP) begin
                            state_q <= ST_HALT;   // pc stays on the NOP-halt instruction
                        end else begin
                            pc_q    <= npc_d;
                            state_q <= misalign ? ST_HALT : ST_FETCH;
                        end
                    end
                end
                ST_HALT: begin
                    state_q <= ST_HALT;
                end
                default: begin
                    state_q <= ST_FETCH;
                end
            endcase
        end
    end

    // Outputs are straight decodes of the state register.
    assign imem_req    = (state_q == ST_FETCH);
    assign instr_valid = (state_q == ST_DECODE);
    assign halted      = (state_q == ST_HALT);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign pc4         = pc_q + 32'd4;
    assign instr       = instr_q;

endmodule

// File: tb/tb_if_unit.sv
module tb_if_unit;
    import if_unit_pkg::*;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [3:0]  npc_op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        stall;
    logic        halted;

    if_unit dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc4         (pc4),
        .npc_op      (npc_op),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .stall       (stall),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } dec_t;

    logic [31:0] fetch_q[$];
    dec_t        dec_q[$];
    logic [31:0] halt_q[$];

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] model_pc;
    bit          model_halted;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic empty_fail(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s: DUT produced an event with no expectation queued at %0t", name, $time);
    endtask

    // Reference next-PC from the instruction-set rules, plain arithmetic.
    function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] word,
                                               input logic [3:0] op, input logic [31:0] rs,
                                               input logic [31:0] rt);
        logic [31:0] link;
        logic [31:0] tgt;
        shortint     imm;
        int          srs;
        int          srt;
        bit          tk;
        link = cur + 32'd4;
        imm  = word[15:0];
        tgt  = link + 32'(int'(imm) * 4);
        srs  = rs;
        srt  = rt;
        tk   = 1'b0;
        case (op)
            NPC_JUMP:  return {link[31:28], word[25:0], 2'b00};
            NPC_JUMPR: return rs;
            NPC_BEQ:   tk = (srs == srt);
            NPC_BNE:   tk = (srs != srt);
            NPC_BGTZ:  tk = (srs > 0);
            NPC_BLEZ:  tk = (srs <= 0);
            NPC_BLTZ:  tk = (srs < 0);
            NPC_BGEZ:  tk = (srs >= 0);
            default:   tk = 1'b0;
        endcase
        return tk ? tgt : link;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    bit          prev_rst   = 1'b1;
    bit          prev_req   = 1'b0;
    bit          prev_valid = 1'b0;
    bit          prev_halt  = 1'b0;
    bit          prev_ack   = 1'b0;
    bit          prev_stall = 1'b0;
    logic [31:0] held_addr;
    dec_t        held_dec;
    logic [31:0] held_halt_pc;

    always @(negedge clk) begin
        if (rst) begin
            prev_rst   = 1'b1;
            prev_req   = 1'b0;
            prev_valid = 1'b0;
            prev_halt  = 1'b0;
            prev_ack   = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (32'(imem_req) + 32'(instr_valid) + 32'(halted) != 32'd1)
                chk("one_hot_state", {29'd0, imem_req, instr_valid, halted}, 32'd0);

            // fetch side
            if (imem_req && (!prev_req || prev_rst)) begin
                if (fetch_q.size() == 0) empty_fail("fetch_queue");
                else begin
                    held_addr = fetch_q.pop_front();
                    chk("fetch_addr", imem_addr, held_addr);
                    chk("fetch_pc", pc, held_addr);
                end
                if (prev_rst) chk("instr_after_reset", instr, 32'h0);
            end else if (imem_req) begin
                chk("fetch_addr_stable", imem_addr, held_addr);
            end
            if (prev_req && prev_ack && !prev_rst)
                chk("fetch_exit_on_ack", {31'd0, imem_req}, 32'd0);

            // decode side
            if (instr_valid && !prev_valid) begin
                if (dec_q.size() == 0) empty_fail("decode_queue");
                else begin
                    held_dec = dec_q.pop_front();
                    chk("decode_pc", pc, held_dec.pc);
                    chk("decode_pc4", pc4, held_dec.pc + 32'd4);
                    chk("decode_instr", instr, held_dec.word);
                end
            end else if (instr_valid) begin
                chk("stall_pc", pc, held_dec.pc);
                chk("stall_instr", instr, held_dec.word);
            end
            if (prev_valid && !prev_stall)
                chk("decode_exit", {31'd0, instr_valid}, 32'd0);

            // halt side
            if (halted && !prev_halt) begin
                if (halt_q.size() == 0) empty_fail("halt_queue");
                else begin
                    held_halt_pc = halt_q.pop_front();
                    chk("halt_pc", pc, held_halt_pc);
                end
            end else if (halted) begin
                chk("halt_pc_frozen", pc, held_halt_pc);
                chk("halt_no_req", {31'd0, imem_req}, 32'd0);
            end

            prev_rst   = 1'b0;
            prev_req   = imem_req;
            prev_valid = instr_valid;
            prev_halt  = halted;
            prev_ack   = imem_ack;
            prev_stall = stall;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input bit ack_during);
        rst        = 1'b1;
        imem_ack   = ack_during;
        imem_rdata = $urandom;
        step();
        fetch_q.push_back(RESET_VECTOR);
        model_pc     = RESET_VECTOR;
        model_halted = 1'b0;
        rst          = 1'b0;
        imem_ack     = 1'b0;
    endtask

    task automatic hold_halt(input int n);
        repeat (n) begin
            imem_ack   = 1'($urandom_range(0, 1));
            imem_rdata = $urandom;
            npc_op     = 4'($urandom);
            stall      = 1'($urandom_range(0, 1));
            step();
        end
        imem_ack = 1'b0;
        stall    = 1'b0;
    endtask

    task automatic run_instr(input logic [31:0] word, input logic [3:0] op,
                             input logic [31:0] rs, input logic [31:0] rt,
                             input int dly, input int stl);
        logic [31:0] np;
        repeat (dly) begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            step();
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        dec_q.push_back('{model_pc, word});
        step();
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        npc_op     = op;
        rs_data    = rs;
        rt_data    = rt;
        if (stl > 0) begin
            stall = 1'b1;
            repeat (stl) step();
        end
        stall = 1'b0;
        if (op == NPC_NOP) begin
            halt_q.push_back(model_pc);
            model_halted = 1'b1;
        end else begin
            np = model_next(model_pc, word, op, rs, rt);
`ifdef IF_ALIGN_CHECK_EN
            if (np[1:0] != 2'b00) begin
                halt_q.push_back(np);
                model_halted = 1'b1;
            end else begin
                fetch_q.push_back(np);
            end
`else
            np[1:0] = 2'b00;
            fetch_q.push_back(np);
`endif
            model_pc = np;
        end
        step();
        npc_op  = 4'($urandom);
        rs_data = $urandom;
        rt_data = $urandom;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0007;
            2:       return 32'h0000_0008;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", compared);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0]  op;
        logic [31:0] rs;
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; npc_op = NPC_PLUS4;
        rs_data = 32'h0; rt_data = 32'h0; stall = 1'b0;
        model_halted = 1'b0;
        repeat (3) step();
        fetch_q.push_back(RESET_VECTOR);
        model_pc = RESET_VECTOR;
        rst = 1'b0;

        // first instruction with same-cycle ack, then jump back to the reset vector
        run_instr(32'h2008_0005, NPC_JUMPR, 32'h0000_3000, 32'h0, 0, 0);
        // BEQ imm=-1 at 0x3000: taken loops to 0x3000, not taken goes to 0x3004
        run_instr({6'h04, 5'd1, 5'd2, 16'hFFFF}, NPC_BEQ, 32'd7, 32'd7, 0, 0);
        run_instr({6'h04, 5'd1, 5'd2, 16'hFFFF}, NPC_BEQ, 32'd7, 32'd8, 1, 0);
        run_instr({16'h0600, 16'h0010}, NPC_BLTZ, 32'h8000_0000, 32'h0, 0, 0);
        run_instr({16'h0401, 16'h0020}, NPC_BGEZ, 32'h0, 32'h0, 0, 0);
        run_instr({16'h1C00, 16'h0040}, NPC_BGTZ, 32'h0, 32'h0, 0, 0);
        // stall in decode and a slow memory
        run_instr(32'h0123_4567, NPC_PLUS4, 32'h0, 32'h0, 4, 3);
        run_instr({6'h02, 26'h000_0C00}, NPC_JUMP, 32'h0, 32'h0, 2, 1);
        // address wrap
        run_instr(32'h0, NPC_JUMPR, 32'hFFFF_FFFC, 32'h0, 0, 0);
        run_instr(32'h0, 4'hC, 32'h0, 32'h0, 0, 0);
        // misaligned jump-register target
        run_instr(32'h0, NPC_JUMPR, 32'h0000_3012, 32'h0, 0, 0);
        if (model_halted) begin
            hold_halt(5);
            do_reset(1'b1);
        end
        run_instr(32'h0, NPC_PLUS4, 32'h0, 32'h0, 0, 0);
        // reset during an outstanding fetch, with ack in the reset cycle
        imem_ack = 1'b0;
        step(); step();
        do_reset(1'b1);
        // NOP halts, HALT held for 10 cycles
        run_instr(32'h0, NPC_NOP, 32'h0, 32'h0, 1, 0);
        hold_halt(10);
        do_reset(1'b0);

        for (int n = 0; n < 150; n++) begin
            op = 4'($urandom_range(0, 15));
            if (op == NPC_NOP && $urandom_range(0, 3) != 0) op = NPC_PLUS4;
            if (op == NPC_JUMPR)
                rs = ($urandom_range(0, 4) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            else
                rs = pick_operand();
            run_instr($urandom, op, rs, pick_operand(),
                      $urandom_range(0, 3), $urandom_range(0, 2));
            if (model_halted) begin
                hold_halt($urandom_range(2, 5));
                do_reset(1'($urandom_range(0, 1)));
            end else if ($urandom_range(0, 19) == 0) begin
                imem_ack = 1'b0;
                step();
                do_reset(1'b1);
            end
        end

        repeat (3) step();
        chk("fetch_queue_drained", fetch_q.size(), 32'd0);
        chk("decode_queue_drained", dec_q.size(), 32'd0);
        chk("halt_queue_drained", halt_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
